uart_tx: RTL and testbench

- UART transmitter: the send-side counterpart to the existing uart_rx receive path.
- Accepts a parallel byte through a valid/busy handshake and serialises it onto uart_txd.
- Frame format: 8N1 by default, LSB first, idle-high line.
- Sits beside uart_rx in impl_top to echo or report data back to the host at the same bit rate.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 45 ++++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clocking, bit-period derivation and the
// transmitter state encoding. uart_rx and uart_tx both derive their bit
// period from cycles_per_bit() so the two sides agree by construction.
package uart_pkg;

  localparam int unsigned CLK_HZ_DEFAULT   = 50_000_000;
  localparam int unsigned BIT_RATE_DEFAULT = 9600;

  // Clock cycles per line bit; integer division truncates toward zero.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_done on the last cycle of every bit period
// while enabled, and returns to the start of a period when restart is high.
// bit_done is combinational so the owner can change state on that same edge.
module uart_bit_timer #(
  parameter int CYCLES_PER_BIT = 5208
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: restart wins, otherwise count up and wrap at the period end.
  always_comb begin
    count_d  = count_q;
    bit_done = 1'b0;
    if (restart) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST_COUNT) begin
        count_d  = '0;
        bit_done = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/busy handshake and shifts it
// out LSB first as start bit, PAYLOAD_BITS data bits and STOP_BITS stop bits
// on an idle-high line. uart_txd comes straight from a flop, so it never
// glitches, and the async reset forces it high without needing a clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = BIT_RATE_DEFAULT,
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = int'(cycles_per_bit(CLK_HZ, BIT_RATE));
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e               state_q, state_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic [BW-1:0]           idx_q, idx_d;
  logic                    timer_restart;
  logic                    bit_done;

  // The bit timer is held at zero while idle so the start bit gets a full period.
  assign timer_restart = (state_q == IDLE);

  uart_bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (!timer_restart),
    .restart (timer_restart),
    .bit_done(bit_done)
  );

  // Frame sequencing; the data register shifts right so bit 0 is always next.
  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    data_d  = data_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (uart_tx_en) begin
          data_d  = uart_tx_data;
          idx_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = data_q[0];
          data_d  = data_q >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_DATA) begin
            state_d = STOP;
            idx_d   = '0;
            txd_d   = 1'b1;
          end else begin
            idx_d  = idx_q + BW'(1);
            txd_d  = data_q[0];
            data_d = data_q >> 1;
          end
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_done) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drives the line idle immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Three instances share clock and reset:
//   a: defaults (5208 cycles/bit), one full-rate frame
//   b: 50 MHz / 4 Mbit/s -> 12 cycles/bit (truncated), the bulk of the tests
//   c: 7 data bits, 2 stop bits, 115200 bit/s -> 434 cycles/bit
// Expected line levels come from a per-cycle frame model in checkFrame.
module tb_uart_tx;

  localparam int CPB_A = 5208;
  localparam int CPB_B = 12;
  localparam int CPB_C = 434;

  logic       clk;
  logic       resetn;
  logic       en_a, en_b, en_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       txd_a, txd_b, txd_c;
  logic       busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  uart_tx dut_a (
    .clk         (clk),
    .resetn      (resetn),
    .uart_txd    (txd_a),
    .uart_tx_busy(busy_a),
    .uart_tx_en  (en_a),
    .uart_tx_data(data_a)
  );

  uart_tx #(
    .CLK_HZ  (50_000_000),
    .BIT_RATE(4_000_000)
  ) dut_b (
    .clk         (clk),
    .resetn      (resetn),
    .uart_txd    (txd_b),
    .uart_tx_busy(busy_b),
    .uart_tx_en  (en_b),
    .uart_tx_data(data_b)
  );

  uart_tx #(
    .BIT_RATE    (115200),
    .PAYLOAD_BITS(7),
    .STOP_BITS   (2)
  ) dut_c (
    .clk         (clk),
    .resetn      (resetn),
    .uart_txd    (txd_c),
    .uart_tx_busy(busy_c),
    .uart_tx_en  (en_c),
    .uart_tx_data(data_c)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic getTxd(input int sel);
    case (sel)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic logic getBusy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Drive the request pins of one instance.
  task automatic applyStimulus(input int sel, input logic en, input logic [7:0] data);
    case (sel)
      0: begin en_a = en; data_a = data; end
      1: begin en_b = en; data_b = data; end
      default: begin en_c = en; data_c = data[6:0]; end
    endcase
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Raise en just before an edge and check the line falls on that very edge.
  task automatic sendFrame(input int sel, input logic [7:0] data, input string tag);
    @(negedge clk);
    applyStimulus(sel, 1'b1, data);
    @(posedge clk);
    #1;
    checkOutput({tag, "_accept_txd"}, 32'(getTxd(sel)), 32'd0);
    checkOutput({tag, "_accept_busy"}, 32'(getBusy(sel)), 32'd1);
  endtask

  // Starting in frame cycle 0, compare every cycle against the expected
  // start/data/stop waveform, then check the idle state after the last cycle.
  // An optional ignored request pulse is injected at pulse_cycle.
  task automatic checkFrame(input int sel, input logic [7:0] data, input int nbits,
                            input int cpb, input int stopb, input int pulse_cycle,
                            input string tag);
    int   total;
    int   txd_err;
    int   busy_err;
    int   bp;
    logic exp_txd;
    total    = (1 + nbits + stopb) * cpb;
    txd_err  = 0;
    busy_err = 0;
    for (int c = 0; c < total; c++) begin
      bp = c / cpb;
      if (bp == 0)          exp_txd = 1'b0;
      else if (bp <= nbits) exp_txd = data[bp-1];
      else                  exp_txd = 1'b1;
      if (getTxd(sel) !== exp_txd) txd_err++;
      if (getBusy(sel) !== 1'b1)   busy_err++;
      if (pulse_cycle >= 0 && c == pulse_cycle)     applyStimulus(sel, 1'b1, 8'h12);
      if (pulse_cycle >= 0 && c == pulse_cycle + 1) applyStimulus(sel, 1'b0, 8'h12);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_txd_wave_errs"}, 32'(txd_err), 32'd0);
    checkOutput({tag, "_busy_wave_errs"}, 32'(busy_err), 32'd0);
    checkOutput({tag, "_end_txd"}, 32'(getTxd(sel)), 32'd1);
    checkOutput({tag, "_end_busy"}, 32'(getBusy(sel)), 32'd0);
  endtask

  // Directed sequence.
  initial begin
    int idle_err;
    resetn = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    applyStimulus(2, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_txd_a", 32'(txd_a), 32'd1);
    checkOutput("reset_busy_a", 32'(busy_a), 32'd0);
    checkOutput("reset_txd_b", 32'(txd_b), 32'd1);
    checkOutput("reset_busy_b", 32'(busy_b), 32'd0);
    checkOutput("reset_txd_c", 32'(txd_c), 32'd1);
    checkOutput("reset_busy_c", 32'(busy_c), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] 0x55 at default rate");
    sendFrame(0, 8'h55, "a55");
    applyStimulus(0, 1'b0, 8'h00);
    checkFrame(0, 8'h55, 8, CPB_A, 1, -1, "a55");

    $display("[TB] 0x00 then 0xFF");
    sendFrame(1, 8'h00, "b00");
    applyStimulus(1, 1'b0, 8'h00);
    checkFrame(1, 8'h00, 8, CPB_B, 1, -1, "b00");
    sendFrame(1, 8'hFF, "bFF");
    applyStimulus(1, 1'b0, 8'h00);
    checkFrame(1, 8'hFF, 8, CPB_B, 1, -1, "bFF");

    $display("[TB] back-to-back 0xA3, 0x3C with en held");
    sendFrame(1, 8'hA3, "bA3");
    applyStimulus(1, 1'b1, 8'h3C);
    checkFrame(1, 8'hA3, 8, CPB_B, 1, -1, "bA3");
    @(posedge clk);
    #1;
    checkOutput("b2b_second_start_txd", 32'(txd_b), 32'd0);
    checkOutput("b2b_second_start_busy", 32'(busy_b), 32'd1);
    applyStimulus(1, 1'b0, 8'h00);
    checkFrame(1, 8'h3C, 8, CPB_B, 1, -1, "b3C");

    $display("[TB] request pulse during 0xC4 frame");
    sendFrame(1, 8'hC4, "bC4");
    applyStimulus(1, 1'b0, 8'h00);
    checkFrame(1, 8'hC4, 8, CPB_B, 1, 50, "bC4");
    idle_err = 0;
    for (int i = 0; i < 2 * CPB_B; i++) begin
      if (busy_b !== 1'b0 || txd_b !== 1'b1) idle_err++;
      @(posedge clk);
      #1;
    end
    checkOutput("bC4_no_queued_frame", 32'(idle_err), 32'd0);

    $display("[TB] reset in mid-frame");
    sendFrame(1, 8'h0F, "b0F");
    applyStimulus(1, 1'b0, 8'h00);
    repeat (60) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midframe_txd_low", 32'(txd_b), 32'd0);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_txd", 32'(txd_b), 32'd1);
    checkOutput("async_reset_busy", 32'(busy_b), 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sendFrame(1, 8'h7E, "b7E");
    applyStimulus(1, 1'b0, 8'h00);
    checkFrame(1, 8'h7E, 8, CPB_B, 1, -1, "b7E");

    $display("[TB] 7 data bits, 2 stop bits, 0x5A");
    sendFrame(2, 8'h5A, "c5A");
    applyStimulus(2, 1'b0, 8'h00);
    checkFrame(2, 8'h5A, 7, CPB_C, 2, -1, "c5A");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
